// File: rtl/ptp_as_pkg.sv
// rtl/ptp_as_pkg.sv - shared PTP AS dispatcher state encoding and metadata layout
package ptp_as_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_DROP,
        ST_DONE
    } tx_state_e;

    localparam int EGRESS_LSB = 11;
    localparam int EGRESS_W   = 8;

    // Field layout of the low 64 metadata bits as produced by the AS engine
    typedef struct packed {
        logic [11:0] rsvd_hi;
        logic [7:0]  frame_type;
        logic [24:0] rsvd_mid;
        logic [7:0]  egress_bitmap;
        logic [6:0]  ts_addr;
        logic [3:0]  rsvd_lo;
    } ptp_meta_t;

endpackage

// File: rtl/ptp_tx_ack_timer.sv
// rtl/ptp_tx_ack_timer.sv - load/count/expire counter bounding the MAC ack wait
module ptp_tx_ack_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic count_en,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt;

    // Expires in the LIMIT-th counting cycle so the request stays up exactly LIMIT cycles
    assign expire = count_en && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= '0;
        end else if (count_en && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ptp_tx_dispatch.sv
// rtl/ptp_tx_dispatch.sv - one-frame-at-a-time PTP egress dispatcher to a single TX MAC port
// Optional ack timeout enabled by defining PTP_TX_DISPATCH_TIMEOUT_EN.
module ptp_tx_dispatch
    import ptp_as_pkg::*;
#(
    parameter int METADATA_WIDTH   = 64,
    parameter int CROSS_DATA_WIDTH = 8,
    parameter int PORT_NUM         = 8,
    parameter int ACK_TIMEOUT      = 1024
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [CROSS_DATA_WIDTH:0]                 i_as_axi_data,
    input  logic [CROSS_DATA_WIDTH/8-1:0]             i_as_axi_data_keep,
    input  logic                                      i_as_axi_data_valid,
    output logic                                      o_as_axi_data_ready,
    input  logic                                      i_as_axi_data_last,
    input  logic [METADATA_WIDTH-1:0]                 i_as_metadata,
    input  logic                                      i_as_metadata_valid,
    output logic                                      o_as_tx_done,
    output logic                                      o_as_tx_drop,
    input  logic [PORT_NUM-1:0]                       i_mac_port_link,
    output logic [PORT_NUM-1:0]                       o_mac_req,
    input  logic [PORT_NUM-1:0]                       i_mac_ack,
    output logic [PORT_NUM*(CROSS_DATA_WIDTH+1)-1:0]  o_mac_axi_data,
    output logic [PORT_NUM*(CROSS_DATA_WIDTH/8)-1:0]  o_mac_axi_data_keep,
    output logic [PORT_NUM-1:0]                       o_mac_axi_data_valid,
    input  logic [PORT_NUM-1:0]                       i_mac_axi_data_ready,
    output logic [PORT_NUM-1:0]                       o_mac_axi_data_last,
    output logic [METADATA_WIDTH-1:0]                 o_mac_metadata,
    output logic [PORT_NUM-1:0]                       o_mac_metadata_valid
);

    localparam int DW = CROSS_DATA_WIDTH + 1;
    localparam int KW = CROSS_DATA_WIDTH / 8;
    localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    tx_state_e                 state;
    logic [PW-1:0]             target;
    logic [METADATA_WIDTH-1:0] meta_q;
    logic [PORT_NUM-1:0]       req_q;
    logic [PORT_NUM-1:0]       md_valid_q;
    logic                      done_q;
    logic                      drop_q;
    logic [PORT_NUM-1:0]       egress_mask;
    logic [PW-1:0]             first_port;
    logic                      timeout_hit;

    function automatic logic [PORT_NUM-1:0] bitmap_to_mask(input logic [EGRESS_W-1:0] b);
        logic [PORT_NUM-1:0] m;
        m = '0;
        for (int i = 0; i < PORT_NUM && i < EGRESS_W; i++) begin
            m[i] = b[i];
        end
        return m;
    endfunction

    // Scans downwards so the lowest set bit is the last one written
    function automatic logic [PW-1:0] lowest_set(input logic [PORT_NUM-1:0] v);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = PW'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [PORT_NUM-1:0] port_onehot(input logic [PW-1:0] idx);
        logic [PORT_NUM-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

    assign egress_mask = bitmap_to_mask(i_as_metadata[EGRESS_LSB +: EGRESS_W]);
    assign first_port  = lowest_set(egress_mask);

`ifdef PTP_TX_DISPATCH_TIMEOUT_EN
    ptp_tx_ack_timer #(
        .LIMIT    (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (state != ST_REQ),
        .count_en (state == ST_REQ),
        .expire   (timeout_hit)
    );
`else
    logic unused_ack_timeout;
    assign unused_ack_timeout = (ACK_TIMEOUT == 0);
    assign timeout_hit        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            target     <= '0;
            meta_q     <= '0;
            req_q      <= '0;
            md_valid_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            md_valid_q <= '0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_as_metadata_valid) begin
                        meta_q <= i_as_metadata;
                        target <= first_port;
                        if (egress_mask == '0 || !i_mac_port_link[first_port]) begin
                            state <= ST_DROP;
                        end else begin
                            state <= ST_REQ;
                            req_q <= port_onehot(first_port);
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mac_ack[target]) begin
                        req_q      <= '0;
                        md_valid_q <= port_onehot(target);
                        state      <= ST_XFER;
                    end else if (!i_mac_port_link[target] || timeout_hit) begin
                        req_q <= '0;
                        state <= ST_DROP;
                    end
                end
                ST_XFER: begin
                    if (i_as_axi_data_valid && o_as_axi_data_ready && i_as_axi_data_last) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (i_as_axi_data_valid && i_as_axi_data_last) begin
                        state  <= ST_DONE;
                        done_q <= 1'b1;
                        drop_q <= 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Zero-latency pass-through steered by the registered target
    always_comb begin
        o_as_axi_data_ready  = 1'b0;
        o_mac_axi_data       = '0;
        o_mac_axi_data_keep  = '0;
        o_mac_axi_data_valid = '0;
        o_mac_axi_data_last  = '0;
        if (state == ST_XFER) begin
            o_as_axi_data_ready = i_mac_axi_data_ready[target];
            for (int p = 0; p < PORT_NUM; p++) begin
                if (target == PW'(p)) begin
                    o_mac_axi_data[p*DW +: DW]      = i_as_axi_data;
                    o_mac_axi_data_keep[p*KW +: KW] = i_as_axi_data_keep;
                    o_mac_axi_data_valid[p]         = i_as_axi_data_valid;
                    o_mac_axi_data_last[p]          = i_as_axi_data_last;
                end
            end
        end else if (state == ST_DROP) begin
            o_as_axi_data_ready = 1'b1;
        end
    end

    assign o_mac_req            = req_q;
    assign o_mac_metadata       = meta_q;
    assign o_mac_metadata_valid = md_valid_q;
    assign o_as_tx_done         = done_q;
    assign o_as_tx_drop         = drop_q;

endmodule

// File: tb/tb_ptp_tx_dispatch.sv
// tb/tb_ptp_tx_dispatch.sv - randomized self-checking bench for ptp_tx_dispatch
`timescale 1ns/1ps
module tb_ptp_tx_dispatch;

    localparam int MW  = 64;
    localparam int CDW = 8;
    localparam int PN  = 8;
    localparam int TMO = 16;
    localparam int DW  = CDW + 1;
    localparam int KW  = CDW / 8;
`ifdef PTP_TX_DISPATCH_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic [DW-1:0]     i_as_axi_data;
    logic [KW-1:0]     i_as_axi_data_keep;
    logic              i_as_axi_data_valid;
    logic              o_as_axi_data_ready;
    logic              i_as_axi_data_last;
    logic [MW-1:0]     i_as_metadata;
    logic              i_as_metadata_valid;
    logic              o_as_tx_done;
    logic              o_as_tx_drop;
    logic [PN-1:0]     i_mac_port_link;
    logic [PN-1:0]     o_mac_req;
    logic [PN-1:0]     i_mac_ack;
    logic [PN*DW-1:0]  o_mac_axi_data;
    logic [PN*KW-1:0]  o_mac_axi_data_keep;
    logic [PN-1:0]     o_mac_axi_data_valid;
    logic [PN-1:0]     i_mac_axi_data_ready;
    logic [PN-1:0]     o_mac_axi_data_last;
    logic [MW-1:0]     o_mac_metadata;
    logic [PN-1:0]     o_mac_metadata_valid;

    ptp_tx_dispatch #(
        .METADATA_WIDTH   (MW),
        .CROSS_DATA_WIDTH (CDW),
        .PORT_NUM         (PN),
        .ACK_TIMEOUT      (TMO)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_as_axi_data        (i_as_axi_data),
        .i_as_axi_data_keep   (i_as_axi_data_keep),
        .i_as_axi_data_valid  (i_as_axi_data_valid),
        .o_as_axi_data_ready  (o_as_axi_data_ready),
        .i_as_axi_data_last   (i_as_axi_data_last),
        .i_as_metadata        (i_as_metadata),
        .i_as_metadata_valid  (i_as_metadata_valid),
        .o_as_tx_done         (o_as_tx_done),
        .o_as_tx_drop         (o_as_tx_drop),
        .i_mac_port_link      (i_mac_port_link),
        .o_mac_req            (o_mac_req),
        .i_mac_ack            (i_mac_ack),
        .o_mac_axi_data       (o_mac_axi_data),
        .o_mac_axi_data_keep  (o_mac_axi_data_keep),
        .o_mac_axi_data_valid (o_mac_axi_data_valid),
        .i_mac_axi_data_ready (i_mac_axi_data_ready),
        .o_mac_axi_data_last  (o_mac_axi_data_last),
        .o_mac_metadata       (o_mac_metadata),
        .o_mac_metadata_valid (o_mac_metadata_valid)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit outputs_idle();
        return ~|{o_as_axi_data_ready, o_as_tx_done, o_as_tx_drop, o_mac_req, o_mac_axi_data,
                  o_mac_axi_data_keep, o_mac_axi_data_valid, o_mac_axi_data_last,
                  o_mac_metadata, o_mac_metadata_valid};
    endfunction

    task automatic drive_idle();
        i_as_axi_data        = '0;
        i_as_axi_data_keep   = '0;
        i_as_axi_data_valid  = 1'b0;
        i_as_axi_data_last   = 1'b0;
        i_as_metadata_valid  = 1'b0;
        i_mac_ack            = '0;
        i_mac_axi_data_ready = '0;
    endtask

    // One frame from metadata to done, checked against the dispatch rules
    task automatic run_frame(input string name, input logic [7:0] bmap, input logic [7:0] link,
                             input int nbeats, input int ack_dly, input int ready_pct,
                             input int rst_beat);
        logic [DW-1:0] bd[$];
        logic [KW-1:0] bk[$];
        logic [MW-1:0] meta0;
        logic [7:0]    lsb;
        logic [PN-1:0] tmask;
        int  exp_port, exp_req, budget;
        bit  exp_drop, tmo, rst_fired, drop_seen;
        int  cyc, sent, rx, last_cyc, done_cyc, done_cnt, req_first, req_cyc;
        int  req_other, md_cnt, md_other, md_bad, bad_beats, other_rx, mirror_bad, late_done;

        lsb      = bmap & (~bmap + 8'd1);
        exp_port = (bmap == 8'd0) ? -1 : $clog2(lsb);
        exp_drop = (exp_port < 0) || !link[exp_port];
        tmo      = !exp_drop && TMO_EN && (ack_dly >= TMO);
        exp_req  = exp_drop ? 0 : (tmo ? TMO : ack_dly + 1);
        exp_drop = exp_drop || tmo;
        tmask    = (exp_port < 0) ? '0 : (PN'(1) << exp_port);
        budget   = nbeats * 8 + ack_dly + 100;

        for (int i = 0; i < nbeats; i++) begin
            bd.push_back(DW'($urandom));
            bk.push_back(KW'($urandom));
        end
        meta0 = {$urandom, $urandom};
        meta0[18:11] = bmap;

        cyc = 0; sent = 0; rx = 0; last_cyc = -10; done_cyc = -10; done_cnt = 0;
        req_first = -1; req_cyc = 0; req_other = 0; md_cnt = 0; md_other = 0; md_bad = 0;
        bad_beats = 0; other_rx = 0; mirror_bad = 0; rst_fired = 1'b0; drop_seen = 1'b0;

        @(posedge clk); #1;
        i_mac_port_link      = link;
        i_as_metadata_valid  = 1'b1;
        i_as_metadata        = meta0;
        i_as_axi_data_valid  = 1'b1;
        i_as_axi_data        = bd[0];
        i_as_axi_data_keep   = bk[0];
        i_as_axi_data_last   = (nbeats == 1);
        i_mac_axi_data_ready = (ready_pct >= 100) ? '1 : PN'($urandom);
        i_mac_ack            = PN'($urandom) & ~tmask;

        while (1) begin
            @(negedge clk);
            for (int p = 0; p < PN; p++) begin
                if (o_mac_req[p]) begin
                    if (p == exp_port) begin
                        req_cyc++;
                        if (req_first < 0) req_first = cyc;
                    end else begin
                        req_other++;
                    end
                end
                if (o_mac_metadata_valid[p]) begin
                    if (p == exp_port) begin
                        md_cnt++;
                        if (o_mac_metadata !== meta0) md_bad++;
                    end else begin
                        md_other++;
                    end
                end
                if (o_mac_axi_data_valid[p] && i_mac_axi_data_ready[p]) begin
                    if (p == exp_port) begin
                        if (rx >= nbeats || o_mac_axi_data[p*DW +: DW] !== bd[rx] ||
                            o_mac_axi_data_keep[p*KW +: KW] !== bk[rx] ||
                            o_mac_axi_data_last[p] !== (rx == nbeats - 1)) bad_beats++;
                        rx++;
                    end else begin
                        other_rx++;
                    end
                end
            end
            if (exp_port >= 0 && o_mac_axi_data_valid[exp_port] &&
                o_as_axi_data_ready !== i_mac_axi_data_ready[exp_port]) mirror_bad++;
            if (i_as_axi_data_valid && o_as_axi_data_ready) begin
                if (i_as_axi_data_last) last_cyc = cyc;
                sent++;
            end
            if (o_as_tx_done) begin
                done_cnt++;
                done_cyc  = cyc;
                drop_seen = o_as_tx_drop;
            end
            if (rst_fired) begin
                @(posedge clk); #1;
                rst = 1'b0;
                drive_idle();
                @(negedge clk);
                chk({name, ":rst_outputs_zero"}, outputs_idle(), 1);
                late_done = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    if (o_as_tx_done || (o_mac_req != '0)) late_done++;
                end
                chk({name, ":rst_no_done"}, late_done, 0);
                return;
            end
            if (done_cnt > 0 || cyc >= budget) break;

            @(posedge clk); #1;
            cyc++;
            i_as_metadata_valid = (cyc == 4);
            if (cyc == 4) i_as_metadata = {$urandom, $urandom};
            i_as_axi_data_valid = (sent < nbeats);
            if (sent < nbeats) begin
                i_as_axi_data      = bd[sent];
                i_as_axi_data_keep = bk[sent];
                i_as_axi_data_last = (sent == nbeats - 1);
            end else begin
                i_as_axi_data_last = 1'b0;
            end
            i_mac_axi_data_ready = (ready_pct >= 100) ? '1 : PN'($urandom);
            i_mac_ack = PN'($urandom) & ~tmask;
            if (exp_port >= 0 && req_first >= 0 && cyc >= req_first + ack_dly) i_mac_ack[exp_port] = 1'b1;
            if (rst_beat >= 0 && sent == rst_beat && !rst_fired) begin
                rst = 1'b1;
                rst_fired = 1'b1;
            end
        end

        chk({name, ":done"}, done_cnt, 1);
        chk({name, ":drop"}, drop_seen, exp_drop);
        chk({name, ":done_latency"}, done_cyc - last_cyc, 1);
        chk({name, ":rx_beats"}, rx, exp_drop ? 0 : nbeats);
        chk({name, ":bad_beats"}, bad_beats, 0);
        chk({name, ":other_port_rx"}, other_rx, 0);
        chk({name, ":md_strobe"}, md_cnt, exp_drop ? 0 : 1);
        chk({name, ":md_other"}, md_other, 0);
        chk({name, ":md_value"}, md_bad, 0);
        chk({name, ":req_cycles"}, req_cyc, exp_req);
        chk({name, ":req_other"}, req_other, 0);
        chk({name, ":ready_mirror"}, mirror_bad, 0);
        chk({name, ":meta_hold"}, (o_mac_metadata === meta0), 1);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk({name, ":done_pulse_width"}, o_as_tx_done, 0);
    endtask

    initial begin
        logic [7:0] bm, lk;
        rst = 1'b1;
        i_as_metadata   = '0;
        i_mac_port_link = '1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_zero", outputs_idle(), 1);

        run_frame("port2_60b",   8'b0000_0100, 8'hff, 60, 3, 100, -1);
        run_frame("bitmap_5_7",  8'b1010_0000, 8'hff, 10, 2, 100, -1);
        run_frame("bitmap_zero", 8'b0000_0000, 8'hff,  8, 2, 100, -1);
        run_frame("port3_toggle",8'b0000_1000, 8'hff, 64, 1,  50, -1);
        run_frame("link_down",   8'b0000_0010, 8'hfd,  5, 1, 100, -1);
        if (TMO_EN) run_frame("ack_timeout", 8'b0001_0000, 8'hff, 6, 100, 100, -1);
        else        run_frame("ack_wait_1000", 8'b0001_0000, 8'hff, 6, 1000, 100, -1);
        run_frame("rst_mid_xfer", 8'b0100_0000, 8'hff, 40, 2, 100, 10);
        run_frame("post_rst_p0",  8'b0000_0001, 8'hff, 12, 2, 100, -1);

        for (int f = 0; f < 20; f++) begin
            bm = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            lk = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hff;
            run_frame("random", bm, lk, $urandom_range(1, 20), $urandom_range(1, 6),
                      ($urandom_range(0, 1) == 1) ? 100 : 50, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ptp_tx_dispatch.md
# ptp_tx_dispatch

Egress counterpart of the PTP receive arbiter: accepts PTP frames (AXI-stream data plus metadata) generated by the TSN AS (802.1AS) engine and delivers each to exactly one TX MAC port using that port's req/ack handshake. One frame is in flight at a time. The block sits between the AS engine output and the per-port TX MAC inputs of the switch core.

## Interface
Parameters:
- METADATA_WIDTH, 64, metadata bus width
- CROSS_DATA_WIDTH, 8, stream data width; data buses are CROSS_DATA_WIDTH+1 bits wide, MSB carried transparently
- PORT_NUM, 8, number of TX MAC ports (index 0..PORT_NUM-1)
- ACK_TIMEOUT, 1024, cycles to wait for ack before dropping (timeout build only)

Ports:
- i_clk, in, 1, 250 MHz core clock
- i_rst, in, 1, synchronous, active-high reset
- i_as_axi_data, in, CROSS_DATA_WIDTH+1, frame data from AS engine
- i_as_axi_data_keep, in, CROSS_DATA_WIDTH/8, byte-valid mask
- i_as_axi_data_valid, in, 1, data valid
- o_as_axi_data_ready, out, 1, backpressure to AS engine
- i_as_axi_data_last, in, 1, last beat of frame
- i_as_metadata, in, METADATA_WIDTH, frame metadata; [18:11] egress port bitmap, [10:4] timestamp addr
- i_as_metadata_valid, in, 1, metadata strobe, one cycle per frame, at or before first data beat
- o_as_tx_done, out, 1, one-cycle pulse: frame delivered or dropped
- o_as_tx_drop, out, 1, qualifies o_as_tx_done: frame dropped
- i_mac_port_link, in, PORT_NUM, per-port link status
- o_mac_req, out, PORT_NUM, per-port transmit request
- i_mac_ack, in, PORT_NUM, per-port request acknowledge (pulse or level)
- o_mac_axi_data, out, PORT_NUM*(CROSS_DATA_WIDTH+1), per-port data, slice p for port p
- o_mac_axi_data_keep, out, PORT_NUM*(CROSS_DATA_WIDTH/8), per-port keep
- o_mac_axi_data_valid, out, PORT_NUM, per-port valid
- i_mac_axi_data_ready, in, PORT_NUM, per-port ready
- o_mac_axi_data_last, out, PORT_NUM, per-port last
- o_mac_metadata, out, METADATA_WIDTH, captured metadata, shared by all ports
- o_mac_metadata_valid, out, PORT_NUM, one-cycle per-port metadata strobe

## Operation
- FSM states: IDLE, REQ, XFER, DROP, DONE.
- IDLE: o_as_axi_data_ready=0. On i_as_metadata_valid, capture metadata and select the lowest set bit of [18:11] as target port. Bitmap zero, or target link down -> DROP; otherwise -> REQ.
- REQ: o_mac_req[target]=1 (level) until ack is sampled. Ack -> XFER, pulse o_mac_metadata_valid[target] in the first XFER cycle. Target link falls -> DROP. Acks on non-target ports are ignored.
- XFER: zero-latency pass-through. o_mac_axi_*[target] = i_as_axi_*; o_as_axi_data_ready = i_mac_axi_data_ready[target]. All other ports' valid=0. Beat with valid&ready&last -> DONE. Link drop mid-frame is not aborted; the frame completes.
- DROP: o_as_axi_data_ready=1, and input beats are discarded until valid&last -> DONE with drop flag set.
- DONE: o_as_tx_done=1 and o_as_tx_drop=drop flag for one cycle -> IDLE.
- Multi-bit bitmap: only the lowest-index port is served. Replication across ports is the AS engine's job.
- i_as_metadata_valid outside IDLE is ignored.

## Timing
- Reset values: all outputs 0; state IDLE; captured metadata 0.
- Metadata to o_mac_req: 1 cycle. Ack to first forwardable beat: 1 cycle. Data path latency: 0 cycles, combinational mux on a registered select.
- Last beat to o_as_tx_done: 1 cycle. Earliest next metadata accepted: 2 cycles after the last beat.
- Reset asserted mid-frame: immediate return to IDLE, req/valid dropped the next edge, no done pulse.

## Configuration
- PTP_TX_DISPATCH_TIMEOUT_EN defined: a counter runs in REQ; on reaching ACK_TIMEOUT without ack, req is deasserted and the FSM goes to DROP. The counter is cleared on entering REQ.
- Not defined: REQ waits indefinitely and exits only on ack or link down. ACK_TIMEOUT is unused.

## Structure
- Shared package ptp_as_pkg: FSM state enum, metadata field offsets (egress bitmap [18:11], timestamp addr [10:4], frame type [51:44]).
- Sub-module ptp_tx_ack_timer: load/count/expire counter, instantiated only under PTP_TX_DISPATCH_TIMEOUT_EN.
- Lowest-set-bit priority encoder: local function.

## Test plan
- Bitmap 8'b0000_0100, port 2 link up, ack 3 cycles after req, 60-beat frame -> only port 2 sees valid/last, metadata strobe once, done=1 and drop=0 one cycle after last.
- Bitmap 8'b1010_0000 -> req on port 5 only; port 7 outputs stay 0.
- Bitmap 0 -> no req; input drained with ready=1; done=1, drop=1.
- Port 3 ready toggled 50% during XFER -> o_as_axi_data_ready mirrors it beat-for-beat; all 64 bytes arrive in order.
- Timeout build, ACK_TIMEOUT=16, no ack -> req falls after 16 cycles, frame drained, drop=1. Non-timeout build -> req held 1000 cycles, then ack completes the frame normally.
- i_rst pulsed mid-XFER -> all outputs 0 the next cycle; a following frame to port 0 is delivered correctly.
